fft_frame_scheduler: RTL

Sequences the audio FFT datapath: the frame BRAM writer, the BRAM-to-FFT streamer, the FFT magnitude core, and the peak-bucket sampler. It replaces the free-running fixed FFT start pulse with a hop-driven scheduler.
- A frame starts only after the frame buffer is fully filled and HOP_SAMPLES new oversampled samples have arrived.
- A minimum period is enforced between frame starts.
- Each stage is tracked by handshakes, guarded by a watchdog, and counted for status.

---
 rtl/fft_frame_scheduler_pkg.sv | 19 +
 rtl/fft_frame_scheduler_sat_counter.sv | 29 ++
 rtl/fft_frame_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_scheduler_pkg.sv
// fft_sched_pkg: shared types and constants for the FFT frame scheduler.
//   state_t     - scheduler FSM state, 3-bit encoding exported on state_o
//   OVERRUN_MAX - saturation ceiling of the dropped-hop counter
//   ERROR_MAX   - saturation ceiling of the aborted-frame counter
package fft_sched_pkg;

  typedef enum logic [2:0] {
    ST_FILL      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_SEND      = 3'd2,
    ST_TRANSFORM = 3'd3,
    ST_ANALYZE   = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  localparam logic [7:0] OVERRUN_MAX = 8'hFF;
  localparam logic [7:0] ERROR_MAX   = 8'hFF;

endpackage

// File: rtl/fft_frame_scheduler_sat_counter.sv
// sat_counter: up-counter that stops at LIMIT, with synchronous clear.
//   clk       - clock
//   rst_n     - asynchronous active-low reset, loads RESET_VAL
//   inc       - count up by one unless already at LIMIT
//   clr       - synchronous clear to zero, wins over inc
//   count     - current count
module sat_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LIMIT     = '1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: hop-driven sequencer for the audio FFT datapath.
// A frame starts once the frame buffer has been filled, a hop of new
// samples has arrived and the minimum start-to-start period has elapsed.
// Each stage is followed through handshake snoops and guarded by a
// per-state watchdog.
//   clk_104mhz    - system clock
//   rst_n         - asynchronous active-low reset
//   enable        - allow new frames (an in-flight frame always completes)
//   sample_we     - one pulse per sample written to the frame BRAM
//   frame_tvalid/frame_tready/frame_tlast - streamer-to-FFT AXIS snoop
//   last_missing  - FFT core framing error pulse
//   mag_tvalid/mag_tlast - magnitude stream snoop
//   sampler_done  - peak search complete pulse
//   fft_start     - start pulse to the streamer
//   sampler_start - start pulse to the peak sampler
//   fft_abort     - pulse while recovering from an error
//   result_valid  - pulse when a frame's peak index is ready
//   busy          - high while a frame is in flight
//   state_o       - current FSM state
//   frames_done   - completed frames (wrapping)
//   overrun_cnt   - dropped hops (saturating)
//   error_cnt     - aborted frames (saturating)
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int FRAME_LEN      = 4096,
  parameter int HOP_SAMPLES    = 1024,
  parameter int MIN_PERIOD     = 1_733_333,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk_104mhz,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_we,
  input  logic        frame_tvalid,
  input  logic        frame_tready,
  input  logic        frame_tlast,
  input  logic        last_missing,
  input  logic        mag_tvalid,
  input  logic        mag_tlast,
  input  logic        sampler_done,
  output logic        fft_start,
  output logic        sampler_start,
  output logic        fft_abort,
  output logic        result_valid,
  output logic        busy,
  output logic [2:0]  state_o,
  output logic [15:0] frames_done,
  output logic [7:0]  overrun_cnt,
  output logic [7:0]  error_cnt
);

  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int HW = (HOP_SAMPLES > 1) ? $clog2(HOP_SAMPLES) : 1;
  localparam int PW = (MIN_PERIOD > 1) ? $clog2(MIN_PERIOD) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [FW-1:0] FILL_FULL = FW'(FRAME_LEN);
  localparam logic [HW-1:0] HOP_LAST  = HW'(HOP_SAMPLES - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(MIN_PERIOD - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [FW-1:0] fill_cnt;
  logic [HW-1:0] hop_cnt;
  logic          hop_pending;
  logic [PW-1:0] per_cnt;
  logic [WW-1:0] wd_cnt;

  logic fill_ok;
  logic per_ok;
  logic hop_wrap;
  logic hop_consume;
  logic overrun_evt;
  logic start_go;
  logic active;
  logic err_go;

  assign fill_ok  = (fill_cnt == FILL_FULL);
  assign per_ok   = (per_cnt == PER_LAST);
  assign hop_wrap = fill_ok && sample_we && (hop_cnt == HOP_LAST);
  assign start_go = (state == ST_WAIT) && enable && hop_pending && per_ok;
  assign active   = (state == ST_SEND) || (state == ST_TRANSFORM) ||
                    (state == ST_ANALYZE);

  // A framing error from the FFT core or an expired watchdog both pre-empt
  // whatever handshake the current state was waiting for.
  assign err_go = (((state == ST_SEND) || (state == ST_TRANSFORM)) && last_missing) ||
                  (active && (wd_cnt == WD_LAST));

  // A pending hop is used up by a frame start, and discarded by error recovery
  // so a stale hop cannot immediately restart a frame that just failed.
  assign hop_consume = start_go || (state == ST_ERROR);
  assign overrun_evt = hop_wrap && hop_pending && !hop_consume;

  sat_counter #(.WIDTH(FW), .LIMIT(FILL_FULL), .RESET_VAL('0)) u_fill_cnt (
    .clk   (clk_104mhz),
    .rst_n (rst_n),
    .inc   (sample_we),
    .clr   (1'b0),
    .count (fill_cnt)
  );

  // Preset to its ceiling so the very first frame is not held back.
  sat_counter #(.WIDTH(PW), .LIMIT(PER_LAST), .RESET_VAL(PER_LAST)) u_per_cnt (
    .clk   (clk_104mhz),
    .rst_n (rst_n),
    .inc   (1'b1),
    .clr   (start_go),
    .count (per_cnt)
  );

  sat_counter #(.WIDTH(8), .LIMIT(OVERRUN_MAX), .RESET_VAL(8'd0)) u_overrun_cnt (
    .clk   (clk_104mhz),
    .rst_n (rst_n),
    .inc   (overrun_evt),
    .clr   (1'b0),
    .count (overrun_cnt)
  );

  sat_counter #(.WIDTH(8), .LIMIT(ERROR_MAX), .RESET_VAL(8'd0)) u_error_cnt (
    .clk   (clk_104mhz),
    .rst_n (rst_n),
    .inc   (err_go),
    .clr   (1'b0),
    .count (error_cnt)
  );

  // Hop tracking only begins once the buffer holds a full frame. A new hop
  // landing in the same cycle a frame consumes the old one keeps the flag set.
  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      hop_cnt     <= '0;
      hop_pending <= 1'b0;
    end else begin
      if (fill_ok && sample_we) begin
        hop_cnt <= hop_wrap ? '0 : hop_cnt + 1'b1;
      end
      if (hop_wrap) begin
        hop_pending <= 1'b1;
      end else if (hop_consume) begin
        hop_pending <= 1'b0;
      end
    end
  end

  // Scheduler FSM. Pulse outputs default low each cycle; the watchdog count
  // restarts on every transition.
  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_FILL;
      fft_start     <= 1'b0;
      sampler_start <= 1'b0;
      fft_abort     <= 1'b0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      frames_done   <= '0;
      wd_cnt        <= '0;
    end else begin
      fft_start     <= 1'b0;
      sampler_start <= 1'b0;
      fft_abort     <= 1'b0;
      result_valid  <= 1'b0;
      if (wd_cnt != WD_LAST) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (err_go) begin
        state     <= ST_ERROR;
        fft_abort <= 1'b1;
        busy      <= 1'b0;
        wd_cnt    <= '0;
      end else begin
        case (state)
          ST_FILL: begin
            if (fill_ok) begin
              state  <= ST_WAIT;
              wd_cnt <= '0;
            end
          end
          ST_WAIT: begin
            if (start_go) begin
              state     <= ST_SEND;
              fft_start <= 1'b1;
              busy      <= 1'b1;
              wd_cnt    <= '0;
            end
          end
          ST_SEND: begin
            if (frame_tvalid && frame_tready && frame_tlast) begin
              state  <= ST_TRANSFORM;
              wd_cnt <= '0;
            end
          end
          ST_TRANSFORM: begin
            if (mag_tvalid && mag_tlast) begin
              state         <= ST_ANALYZE;
              sampler_start <= 1'b1;
              wd_cnt        <= '0;
            end
          end
          ST_ANALYZE: begin
            if (sampler_done) begin
              state        <= ST_WAIT;
              result_valid <= 1'b1;
              frames_done  <= frames_done + 1'b1;
              busy         <= 1'b0;
              wd_cnt       <= '0;
            end
          end
          ST_ERROR: begin
            state  <= ST_WAIT;
            wd_cnt <= '0;
          end
          default: begin
            state  <= ST_FILL;
            busy   <= 1'b0;
            wd_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule
